// File: rtl/typed_record_serializer.sv
// Typed record serializer: packs NUM_FIELDS typed integer fields into a
// little-endian byte buffer and streams it out as OUT_BYTES-wide beats.
`timescale 1ns/1ps
module typed_record_serializer #(
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned OUT_BYTES  = 1,
  parameter bit          WIDEN      = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [64*NUM_FIELDS-1:0]  in_data,
  input  logic [2*NUM_FIELDS-1:0]   in_type,
  input  logic [NUM_FIELDS-1:0]     in_signed,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*OUT_BYTES-1:0]    out_data,
  output logic [OUT_BYTES-1:0]      out_keep,
  output logic                      out_last,
  output logic                      busy
);

  localparam int unsigned NB = 8 * NUM_FIELDS;
  localparam int unsigned PW = $clog2(NB + 1);
  localparam int unsigned OW = 8 * OUT_BYTES;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q;
  logic [8*NB-1:0]        buf_q, buf_d;
  logic [PW-1:0]          len_q, len_d;
  logic [PW-1:0]          ptr_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [OW-1:0]          out_data_q;
  logic [OUT_BYTES-1:0]   out_keep_q;
  logic                   out_last_q;
  logic                   busy_q;

  logic [8*NB-1:0]        src_buf;
  logic [PW-1:0]          src_len;
  logic [PW-1:0]          src_ptr;
  logic [OW-1:0]          beat_data;
  logic [OUT_BYTES-1:0]   beat_keep;
  logic                   beat_last;

  // Pack the offered record into a contiguous byte image and compute its length
  always_comb begin : pack
    int unsigned off;
    int unsigned nbytes;
    logic [63:0] d;
    logic [63:0] ext;
    logic        sx;
    buf_d  = '0;
    off    = 0;
    nbytes = 0;
    d      = '0;
    ext    = '0;
    sx     = 1'b0;
    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
      d  = in_data[64*f +: 64];
      sx = WIDEN & in_signed[f];
      case (in_type[2*f +: 2])
        2'd0:    begin ext = {{56{sx & d[7]}},  d[7:0]};  nbytes = 1; end
        2'd1:    begin ext = {{48{sx & d[15]}}, d[15:0]}; nbytes = 2; end
        2'd2:    begin ext = {{32{sx & d[31]}}, d[31:0]}; nbytes = 4; end
        default: begin ext = d;                           nbytes = 8; end
      endcase
      if (WIDEN) nbytes = 8;
      for (int unsigned b = 0; b < 8; b++) begin
        if (b < nbytes) buf_d[8*(off+b) +: 8] = ext[8*b +: 8];
      end
      off = off + nbytes;
    end
    len_d = PW'(off);
  end

  // Select the first beat from the incoming record in IDLE, else the held buffer
  always_comb begin : beat
    int unsigned p;
    src_buf   = (state_q == IDLE) ? buf_d : buf_q;
    src_len   = (state_q == IDLE) ? len_d : len_q;
    src_ptr   = (state_q == IDLE) ? '0    : ptr_q;
    beat_data = '0;
    beat_keep = '0;
    p         = 0;
    for (int unsigned k = 0; k < OUT_BYTES; k++) begin
      p = 32'(src_ptr) + k;
      if (p < 32'(src_len)) begin
        beat_data[8*k +: 8] = src_buf[8*p +: 8];
        beat_keep[k]        = 1'b1;
      end
    end
    beat_last = (32'(src_ptr) + OUT_BYTES) >= 32'(src_len);
  end

  // Control FSM with registered handshake and beat outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            buf_q       <= buf_d;
            len_q       <= len_d;
            ptr_q       <= PW'(OUT_BYTES);
            out_valid_q <= 1'b1;
            out_data_q  <= beat_data;
            out_keep_q  <= beat_keep;
            out_last_q  <= beat_last;
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              ptr_q       <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_keep_q  <= '0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              ptr_q      <= ptr_q + PW'(OUT_BYTES);
              out_data_q <= beat_data;
              out_keep_q <= beat_keep;
              out_last_q <= beat_last;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_typed_record_serializer.sv
// Bench for typed_record_serializer: four instances with different beat widths
// and widening modes, checked against a byte-queue reference model.
`timescale 1ns/1ps
module tb_typed_record_serializer;

  localparam int unsigned NF = 4;
  localparam int unsigned ND = 4;
  localparam int unsigned OBS [ND] = '{1, 4, 2, 8};
  localparam bit          WS  [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ND-1:0]     in_valid;
  logic [ND-1:0]     out_ready;
  logic [ND-1:0]     ir, ov, ol, bz;
  logic [64*NF-1:0]  in_data;
  logic [2*NF-1:0]   in_type;
  logic [NF-1:0]     in_signed;
  logic [63:0]       od [ND];
  logic [7:0]        ok [ND];

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] t1_bytes [15] = '{8'h11, 8'h33, 8'h22, 8'h77, 8'h66, 8'h55, 8'h44, 8'hFF,
                                8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88};

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [8*OBS[g]-1:0] d;
    logic [OBS[g]-1:0]   k;
    typed_record_serializer #(
      .NUM_FIELDS(NF), .OUT_BYTES(OBS[g]), .WIDEN(WS[g])
    ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(ir[g]),
      .in_data(in_data), .in_type(in_type), .in_signed(in_signed),
      .out_valid(ov[g]), .out_ready(out_ready[g]),
      .out_data(d), .out_keep(k), .out_last(ol[g]), .busy(bz[g])
    );
    assign od[g] = 64'(d);
    assign ok[g] = 8'(k);
  end

  // Reference: expected byte stream from the currently driven record
  task automatic build_expected(input bit w);
    logic [63:0] v;
    int unsigned sz;
    int unsigned n;
    exp_q.delete();
    for (int f = 0; f < NF; f++) begin
      sz = 1 << in_type[2*f +: 2];
      v  = in_data[64*f +: 64];
      if (sz < 8) begin
        v = v % (64'd1 << (8*sz));
        if (w && in_signed[f] && v >= (64'd1 << (8*sz-1))) v = v - (64'd1 << (8*sz));
      end
      n = w ? 8 : sz;
      for (int unsigned b = 0; b < n; b++) exp_q.push_back(8'(v >> (8*b)));
    end
  endtask

  task automatic randomize_record();
    for (int j = 0; j < 2*NF; j++) in_data[32*j +: 32] = $urandom();
    in_type   = 8'($urandom());
    in_signed = 4'($urandom());
  endtask

  task automatic set_t1_record();
    in_data   = {64'h8899AABBCCDDEEFF, 64'h0000000044556677, 64'h0000000000002233, 64'h0000000000000011};
    in_type   = {2'd3, 2'd2, 2'd1, 2'd0};
    in_signed = '0;
  endtask

  // Offer the current record to one instance and consume all beats.
  // mode 0: always ready, 1: random ready, 2: 5-cycle stall at beat 3.
  task automatic run_record(input int id, input int mode, input bit hold, output int acc_wait);
    int ob, nb, L, i, guard, stall;
    bit rdy;
    logic [63:0] expd;
    logic [7:0]  expk;
    ob = OBS[id];
    build_expected(WS[id]);
    L  = exp_q.size();
    nb = (L + ob - 1) / ob;
    in_valid[id] = 1'b1;
    acc_wait = 0;
    while (ir[id] !== 1'b1 && acc_wait < 100) begin
      @(posedge clk); #1;
      acc_wait++;
    end
    checks++;
    if (acc_wait >= 100) begin
      failures++;
      $display("FAIL accept_timeout id=%0d in_ready=%b required=1", id, ir[id]);
      in_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) in_valid[id] = 1'b0;
    randomize_record();
    got_q.delete();
    i = 0; guard = 0; stall = 0;
    while (i < nb && guard < 500) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: begin
          rdy = !(i == 2 && stall < 5);
          if (!rdy) stall++;
        end
      endcase
      out_ready[id] = rdy;
      expd = '0;
      expk = '0;
      for (int k = 0; k < ob; k++) begin
        if (i*ob + k < L) begin
          expd[8*k +: 8] = exp_q[i*ob + k];
          expk[k] = 1'b1;
        end
      end
      checks++;
      if ({ov[id], od[id], ok[id], ol[id], ir[id], bz[id]} !==
          {1'b1, expd, expk, (i == nb-1), 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL beat id=%0d beat=%0d got v=%b d=%h k=%h l=%b ir=%b busy=%b required v=1 d=%h k=%h l=%b ir=0 busy=1",
                 id, i, ov[id], od[id], ok[id], ol[id], ir[id], bz[id], expd, expk, (i == nb-1));
      end
      if (rdy) begin
        for (int k = 0; k < ob; k++) if (ok[id][k]) got_q.push_back(od[id][8*k +: 8]);
      end
      @(posedge clk); #1;
      if (rdy) i++;
      guard++;
    end
    out_ready[id] = 1'b0;
    checks++;
    if (i != nb) begin
      failures++;
      $display("FAIL beat_timeout id=%0d beats=%0d required=%0d", id, i, nb);
    end
    checks++;
    if ({ov[id], ir[id], bz[id]} !== 3'b010) begin
      failures++;
      $display("FAIL return_idle id=%0d v=%b ir=%b busy=%b required v=0 ir=1 busy=0", id, ov[id], ir[id], bz[id]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; out_ready = '0;
    randomize_record();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov, ol, ir, bz} !== 16'h0) begin
      failures++;
      $display("FAIL reset_ctrl v=%b l=%b ir=%b busy=%b required all 0", ov, ol, ir, bz);
    end
    for (int g = 0; g < ND; g++) begin
      checks++;
      if (od[g] !== 64'h0 || ok[g] !== 8'h0) begin
        failures++;
        $display("FAIL reset_data id=%0d d=%h k=%h required 0", g, od[g], ok[g]);
      end
    end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (ir !== 4'h0) begin
      failures++;
      $display("FAIL ready_before_clk ir=%b required=0000", ir);
    end
    @(posedge clk); #1;
    checks++;
    if (ir !== 4'hF) begin
      failures++;
      $display("FAIL ready_after_release ir=%b required=1111", ir);
    end
  endtask

  task automatic test_packed_ob1();
    int w;
    set_t1_record();
    run_record(0, 0, 1'b0, w);
    checks++;
    if (got_q.size() != 15) begin
      failures++;
      $display("FAIL t1_len got=%0d required=15", got_q.size());
    end
    for (int j = 0; j < 15 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== t1_bytes[j]) begin
        failures++;
        $display("FAIL t1_byte idx=%0d got=%h required=%h", j, got_q[j], t1_bytes[j]);
      end
    end
  endtask

  task automatic test_packed_ob4();
    int w;
    set_t1_record();
    run_record(1, 1, 1'b0, w);
    checks++;
    if (got_q.size() != 15) begin
      failures++;
      $display("FAIL t2_len got=%0d required=15", got_q.size());
    end
    for (int j = 0; j < 15 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== t1_bytes[j]) begin
        failures++;
        $display("FAIL t2_byte idx=%0d got=%h required=%h", j, got_q[j], t1_bytes[j]);
      end
    end
  endtask

  task automatic test_widen();
    int w;
    logic [7:0] fill;
    for (int s = 1; s >= 0; s--) begin
      randomize_record();
      in_type[1:0]  = 2'd0;
      in_data[63:0] = 64'hDEADBEEF00C0FF80;
      in_signed[0]  = 1'(s);
      fill = (s == 1) ? 8'hFF : 8'h00;
      run_record(2, 1, 1'b0, w);
      checks++;
      if (got_q.size() != 32 || got_q[0] !== 8'h80) begin
        failures++;
        $display("FAIL widen_head signed=%0d len=%0d b0=%h required len=32 b0=80", s, got_q.size(), got_q[0]);
      end
      for (int j = 1; j < 8 && j < got_q.size(); j++) begin
        checks++;
        if (got_q[j] !== fill) begin
          failures++;
          $display("FAIL widen_ext signed=%0d idx=%0d got=%h required=%h", s, j, got_q[j], fill);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    randomize_record();
    run_record(0, 2, 1'b0, w);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stall_len got=%0d required=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_send();
    int w;
    randomize_record();
    in_type = 8'hFF;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    checks++;
    if (ov[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_accept v=%b required=1", ov[0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ov[0], ol[0], bz[0], ir[0]} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset v=%b l=%b busy=%b ir=%b required all 0", ov[0], ol[0], bz[0], ir[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_release ir=%b required=1", ir[0]);
    end
    randomize_record();
    run_record(0, 0, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    randomize_record();
    in_type = 8'hFF;
    run_record(3, 0, 1'b1, w1);
    randomize_record();
    in_type = 8'hFF;
    run_record(3, 0, 1'b0, w2);
    checks++;
    if (w2 != 0) begin
      failures++;
      $display("FAIL b2b_gap wait=%0d required=0", w2);
    end
  endtask

  task automatic test_random();
    int w, id;
    for (int n = 0; n < 40; n++) begin
      id = $urandom_range(0, ND-1);
      randomize_record();
      run_record(id, 1, 1'b0, w);
    end
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    in_type   = '0;
    in_signed = '0;
    test_reset();
    test_packed_ob1();
    test_packed_ob4();
    test_widen();
    test_backpressure();
    test_reset_mid_send();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
